// File: rtl/mem_pkg.sv
// mem_pkg: shared constants, types and helpers for the DRAM line controller.
// Contents:
//   LINE_BITS, BEATS     default line geometry (512-bit line, 8 beats of 64 bits)
//   ADDR_W, OFF_BITS,
//   IDX_BITS             default address split (byte offset / line index widths)
//   line_t               one full cache line as a packed vector
//   ctrl_state_t         controller FSM states
//   line_index(addr)     storage index of a byte address (upper bits alias)
package mem_pkg;

    localparam int ADDR_W    = 64;
    localparam int LINE_BITS = 512;
    localparam int BEATS     = LINE_BITS / ADDR_W;
    localparam int MEM_LINES = 256;
    localparam int OFF_BITS  = $clog2(LINE_BITS / 8);
    localparam int IDX_BITS  = $clog2(MEM_LINES);

    typedef logic [LINE_BITS-1:0] line_t;

    // Explicit encodings keep the state register layout stable for older tools.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        COMMIT = 2'd2,
        BURST  = 2'd3
    } ctrl_state_t;

    function automatic logic [IDX_BITS-1:0] line_index(input logic [ADDR_W-1:0] addr);
        return addr[OFF_BITS +: IDX_BITS];
    endfunction

endpackage

// File: rtl/line_burst_serializer.sv
// line_burst_serializer: holds one line and streams it out as address-tagged beats.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   load                  capture fill/base and start a burst from beat 0
//   fill [LINE_BITS]      line data, word 0 in bits [W-1:0]
//   base [W]              line base address (offset bits already cleared)
//   resp_valid/ready      beat handshake towards the cache
//   resp_addr, resp_value current beat address and data
//   done                  pulses on the transfer of the last beat
module line_burst_serializer #(
    parameter int W         = 64,
    parameter int LINE_BITS = 512
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [LINE_BITS-1:0] fill,
    input  logic [W-1:0]         base,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [W-1:0]         resp_addr,
    output logic [W-1:0]         resp_value,
    output logic                 done
);
    import mem_pkg::*;

    localparam int BEATS = LINE_BITS / W;
    localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;

    logic [LINE_BITS-1:0] buffer;
    logic [W-1:0]         base_q;
    logic [BW-1:0]        beat;
    logic                 xfer;
    logic                 last;

    assign xfer       = resp_valid && resp_ready;
    assign last       = beat == BW'(BEATS - 1);
    assign done       = xfer && last;
    assign resp_value = buffer[W*int'(beat) +: W];
    assign resp_addr  = base_q + W'(beat) * W'(W / 8);

    // The beat counter parks on the last beat after the burst rather than
    // wrapping, so it never leaves 0..BEATS-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buffer     <= '0;
            base_q     <= '0;
            beat       <= '0;
            resp_valid <= 1'b0;
        end else if (load) begin
            buffer     <= fill;
            base_q     <= base;
            beat       <= '0;
            resp_valid <= 1'b1;
        end else if (xfer) begin
            resp_valid <= !last;
            if (!last)
                beat <= beat + 1'b1;
        end
    end

endmodule

// File: rtl/dram_line_ctrl.sv
// dram_line_ctrl: fixed-latency line memory below the last-level cache.
// Ports:
//   clk_in, rst_N_in          clock, asynchronous active-low reset
//   req_valid_in/ready_out    line request handshake (one outstanding request)
//   req_addr_in [W]           line byte address, offset bits ignored
//   req_we_in                 1 = write-back, 0 = line fill read
//   req_value_in [LINE_BITS]  write-back data, word 0 in bits [W-1:0]
//   resp_valid_out/ready_in   read beat handshake
//   resp_addr_out [W]         beat address = line base + beat*(W/8)
//   resp_value_out [W]        beat data
module dram_line_ctrl #(
    parameter int W         = 64,
    parameter int LINE_BITS = 512,
    parameter int MEM_LINES = 256,
    parameter int LATENCY   = 10
) (
    input  logic                 clk_in,
    input  logic                 rst_N_in,
    input  logic                 req_valid_in,
    output logic                 req_ready_out,
    input  logic [W-1:0]         req_addr_in,
    input  logic                 req_we_in,
    input  logic [LINE_BITS-1:0] req_value_in,
    output logic                 resp_valid_out,
    input  logic                 resp_ready_in,
    output logic [W-1:0]         resp_addr_out,
    output logic [W-1:0]         resp_value_out
);
    import mem_pkg::*;

    localparam int OFF = $clog2(LINE_BITS / 8);
    localparam int IDX = $clog2(MEM_LINES);
    localparam int CW  = LATENCY > 1 ? $clog2(LATENCY) : 1;

    ctrl_state_t          state;
    logic [CW-1:0]        cnt;
    logic [W-1:0]         cap_addr;
    logic                 cap_we;
    logic [LINE_BITS-1:0] cap_data;
    logic                 up;
    logic                 load;
    logic                 done;
    logic [IDX-1:0]       idx;
    logic [W-1:0]         base;

    // Storage stands in for DRAM and is deliberately left out of reset.
    logic [LINE_BITS-1:0] mem [MEM_LINES];

    // up holds ready low through reset and releases it on the first edge after.
    assign req_ready_out = up && state == IDLE;
    assign idx           = cap_addr[OFF +: IDX];
    assign base          = cap_addr & ~W'(LINE_BITS / 8 - 1);
    assign load          = state == WAIT && cnt == '0 && !cap_we;

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            state    <= IDLE;
            cnt      <= '0;
            cap_addr <= '0;
            cap_we   <= 1'b0;
            cap_data <= '0;
            up       <= 1'b0;
        end else begin
            up <= 1'b1;
            case (state)
                IDLE: if (req_valid_in && req_ready_out) begin
                    cnt      <= CW'(LATENCY - 1);
                    cap_addr <= req_addr_in;
                    cap_we   <= req_we_in;
                    cap_data <= req_value_in;
                    state    <= WAIT;
                end
                WAIT: if (cnt == '0)
                    state <= cap_we ? COMMIT : BURST;
                else
                    cnt <= cnt - 1'b1;
                COMMIT: state <= IDLE;
                BURST: if (done)
                    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Whole-line single-cycle commit: a reset can drop a write but never tear it.
    always_ff @(posedge clk_in) begin
        if (state == COMMIT)
            mem[idx] <= cap_data;
    end

    line_burst_serializer #(
        .W         (W),
        .LINE_BITS (LINE_BITS)
    ) u_ser (
        .clk        (clk_in),
        .rst_n      (rst_N_in),
        .load       (load),
        .fill       (mem[idx]),
        .base       (base),
        .resp_valid (resp_valid_out),
        .resp_ready (resp_ready_in),
        .resp_addr  (resp_addr_out),
        .resp_value (resp_value_out),
        .done       (done)
    );

endmodule

// File: tb/tb_dram_line_ctrl.sv
// tb_dram_line_ctrl: directed table-driven bench for dram_line_ctrl.
module tb_dram_line_ctrl;

    localparam int LAT = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [63:0]  req_addr = '0;
    logic         req_we = 1'b0;
    logic [511:0] req_value = '0;
    logic         resp_valid;
    logic         resp_ready = 1'b1;
    logic [63:0]  resp_addr;
    logic [63:0]  resp_value;

    int  errs = 0;
    int  checks = 0;
    int  xfers = 0;
    time acc_t = 0;
    time prev_acc = 0;

    typedef struct {
        logic [63:0] addr;
        logic        we;
        logic [63:0] w0;
        logic        ones;
        logic [63:0] base;
        int          stall;
    } vec_t;

    vec_t tbl [8];

    dram_line_ctrl #(.W(64), .LINE_BITS(512), .MEM_LINES(256), .LATENCY(LAT)) dut (
        .clk_in         (clk),
        .rst_N_in       (rst_n),
        .req_valid_in   (req_valid),
        .req_ready_out  (req_ready),
        .req_addr_in    (req_addr),
        .req_we_in      (req_we),
        .req_value_in   (req_value),
        .resp_valid_out (resp_valid),
        .resp_ready_in  (resp_ready),
        .resp_addr_out  (resp_addr),
        .resp_value_out (resp_value)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (resp_valid && resp_ready) xfers++;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] mk_line(input logic [63:0] w0, input logic ones);
        logic [511:0] d;
        for (int i = 0; i < 8; i++) d[i*64 +: 64] = ones ? '1 : w0 + 64'(i);
        return d;
    endfunction

    // Present a request and hold it until it transfers; returns just after that edge.
    task automatic send(input logic [63:0] a, input logic we, input logic [511:0] d);
        int n = 0;
        req_addr = a; req_we = we; req_value = d; req_valid = 1'b1;
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        if (!req_ready) chk("req_accept_timeout", 64'(n), 64'd0);
        @(posedge clk);
        prev_acc = acc_t;
        acc_t = $time;
        #1 req_valid = 1'b0;
    endtask

    task automatic write_line(input logic [63:0] a, input logic [511:0] d);
        int n = 0;
        send(a, 1'b1, d);
        @(negedge clk);
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        chk("write_ready_return", 64'(req_ready), 64'd1);
    endtask

    task automatic read_line(input logic [63:0] a, input logic [63:0] base,
                             input logic [63:0] w0, input logic ones, input int stall);
        int n = 0;
        logic [63:0] ev;
        send(a, 1'b0, '0);
        xfers = 0;
        @(negedge clk);
        while (!resp_valid && n < 200) begin @(negedge clk); n++; end
        if (!resp_valid) begin
            chk("resp_timeout", 64'(resp_valid), 64'd1);
            return;
        end
        chk("first_beat_latency", 64'(($time + 5 - acc_t) / 10), 64'(LAT + 1));
        for (int k = 0; k < 8; k++) begin
            ev = ones ? '1 : w0 + 64'(k);
            if (stall == k) begin
                resp_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_valid", 64'(resp_valid), 64'd1);
                    chk("stall_addr", resp_addr, base + 64'(8*k));
                    chk("stall_value", resp_value, ev);
                end
                resp_ready = 1'b1;
            end
            chk("beat_valid", 64'(resp_valid), 64'd1);
            chk("beat_addr", resp_addr, base + 64'(8*k));
            chk("beat_value", resp_value, ev);
            @(negedge clk);
        end
        chk("burst_end_valid", 64'(resp_valid), 64'd0);
        chk("burst_xfers", 64'(xfers), 64'd8);
        chk("ready_after_burst", 64'(req_ready), 64'd1);
    endtask

    initial begin
        tbl[0] = '{64'h40,   1'b1, 64'h1000, 1'b0, 64'h40,   -1};
        tbl[1] = '{64'h40,   1'b0, 64'h1000, 1'b0, 64'h40,   -1};
        tbl[2] = '{64'h48,   1'b0, 64'h1000, 1'b0, 64'h40,   -1};
        tbl[3] = '{64'h40,   1'b0, 64'h1000, 1'b0, 64'h40,    3};
        tbl[4] = '{64'h4040, 1'b1, 64'h0,    1'b1, 64'h4000, -1};
        tbl[5] = '{64'h40,   1'b0, 64'h0,    1'b1, 64'h40,   -1};
        tbl[6] = '{64'h2000, 1'b1, 64'hA000, 1'b0, 64'h2000, -1};
        tbl[7] = '{64'h2038, 1'b0, 64'hA000, 1'b0, 64'h2000, -1};

        #12;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_addr", resp_addr, 64'd0);
        chk("rst_resp_value", resp_value, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", 64'(req_ready), 64'd1);

        for (int v = 0; v < 8; v++) begin
            if (tbl[v].we)
                write_line(tbl[v].addr, mk_line(tbl[v].w0, tbl[v].ones));
            else
                read_line(tbl[v].addr, tbl[v].base, tbl[v].w0, tbl[v].ones, tbl[v].stall);
        end

        // Backpressure: a read presented during a write's WAIT must not be taken early.
        send(64'h3000, 1'b1, mk_line(64'hB000, 1'b0));
        req_addr = 64'h40; req_we = 1'b0; req_value = '1; req_valid = 1'b1;
        @(negedge clk);
        chk("bp_ready_in_wait", 64'(req_ready), 64'd0);
        read_line(64'h40, 64'h40, 64'h0, 1'b1, -1);
        chk("bp_accept_gap", 64'((acc_t - prev_acc) / 10), 64'(LAT + 2));
        read_line(64'h3000, 64'h3000, 64'hB000, 1'b0, -1);

        // Reset in the middle of a burst, after beats 0..2 have transferred.
        send(64'h2000, 1'b0, '0);
        begin
            int n = 0;
            @(negedge clk);
            while (!resp_valid && n < 200) begin @(negedge clk); n++; end
        end
        repeat (3) @(negedge clk);
        chk("pre_rst_beat3_addr", resp_addr, 64'h2018);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(resp_valid), 64'd0);
        chk("async_rst_ready", 64'(req_ready), 64'd0);
        chk("async_rst_addr", resp_addr, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_mid_rst", 64'(req_ready), 64'd1);
        read_line(64'h2000, 64'h2000, 64'hA000, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
